memory_arbiter: RTL and testbench

Memory-side responder for the per-core cache blocks. Accepts instruction-fetch and data read/write requests from `CPUS` cores, and serializes them onto the single-ported RAM. For each accepted request it returns wait/load responses. The block sits between the cores' caches and the RAM model, and drives the controller side of the cache/control handshake.

---
 rtl/memory_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_memory_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
// Serializes per-core instruction fetches and data reads/writes onto one
// single-ported RAM and returns per-core wait/load responses.
//
// Build option:
//   MEMARB_FAIRNESS_EN  defined   -> round-robin among cores via pointer rr
//   MEMARB_FAIRNESS_EN  undefined -> fixed priority, lowest core index first
// In both builds data requests beat instruction requests.
//
// Handshake: a core holds its request line (iREN, or dREN/dWEN) high together
// with address/data until the matching wait bit reads 0 in a cycle; that cycle
// is the acknowledge, and the load bus carries ramload only during it. A core
// that is requesting and not being acknowledged always sees wait=1; a core that
// is not requesting sees wait=0. Dropping the request before the acknowledge
// abandons it without a response.
//
// RAM outputs and acknowledges are combinational from state, gnt and inputs;
// state, gnt and rr are the only flops. arb_state mirrors the FSM state
// (IDLE=0, DACC=1, IACC=2) for observation.
module memory_arbiter #(
    parameter int CPUS = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [CPUS-1:0][31:0]  iaddr,
    input  logic [CPUS-1:0][31:0]  daddr,
    input  logic [CPUS-1:0][31:0]  dstore,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [CPUS-1:0][31:0]  iload,
    output logic [CPUS-1:0][31:0]  dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate,
    output logic [1:0]             arb_state
);

    localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [IW:0] CPUS_W = (IW+1)'(CPUS);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   start;
    logic [CPUS-1:0] dreq;
    logic            d_found;
    logic            i_found;
    logic [IW-1:0]   d_idx;
    logic [IW-1:0]   i_idx;
    logic            cur_req;
    logic            ack;

    // Core index (base + inc) modulo CPUS; base < CPUS and inc < CPUS.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                               input logic [IW:0]   inc);
        logic [IW:0] s;
        s = {1'b0, base} + inc;
        if (s >= CPUS_W) begin
            s = s - CPUS_W;
        end
        return s[IW-1:0];
    endfunction

    assign dreq      = dREN | dWEN;
    assign arb_state = state;

`ifdef MEMARB_FAIRNESS_EN
    logic [IW-1:0] rr;
    logic [IW-1:0] next_rr;

    // The search starts at the round-robin pointer.
    assign start   = rr;
    assign next_rr = wrap_add(gnt, (IW+1)'(1));
`else
    // Fixed priority: the search always starts at core 0.
    assign start = '0;
`endif

    // Find the first requesting core at or after start, per request class.
    always_comb begin : pick
        logic [IW-1:0] cand;
        cand    = '0;
        d_found = 1'b0;
        d_idx   = '0;
        i_found = 1'b0;
        i_idx   = '0;
        for (int k = 0; k < CPUS; k++) begin
            cand = wrap_add(start, (IW+1)'(k));
            if (!d_found && dreq[cand]) begin
                d_found = 1'b1;
                d_idx   = cand;
            end
            if (!i_found && iREN[cand]) begin
                i_found = 1'b1;
                i_idx   = cand;
            end
        end
    end

    // The granted request is still held, and whether the RAM completes it now.
    always_comb begin
        cur_req = 1'b0;
        case (state)
            DACC:    cur_req = dreq[gnt];
            IACC:    cur_req = iREN[gnt];
            default: cur_req = 1'b0;
        endcase
        ack = cur_req && (ramstate == RAM_ACCESS);
    end

    // Arbitration FSM: grant in IDLE, hold the RAM until ACCESS, ERROR or abandon.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gnt   <= '0;
`ifdef MEMARB_FAIRNESS_EN
            rr    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (d_found) begin
                        state <= DACC;
                        gnt   <= d_idx;
                    end else if (i_found) begin
                        state <= IACC;
                        gnt   <= i_idx;
                    end
                end
                DACC, IACC: begin
                    if (!cur_req || ramstate == RAM_ERROR) begin
                        // Abandoned or failed: back to IDLE, the request
                        // (if still held) is re-arbitrated from scratch.
                        state <= IDLE;
                    end else if (ramstate == RAM_ACCESS) begin
                        state <= IDLE;
`ifdef MEMARB_FAIRNESS_EN
                        rr    <= next_rr;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM side: drive the granted core's request; nothing in IDLE.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DACC: begin
                // A write wins when a core raises both enables.
                ramWEN   = dWEN[gnt];
                ramREN   = dREN[gnt] & ~dWEN[gnt];
                ramaddr  = daddr[gnt];
                ramstore = dstore[gnt];
            end
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[gnt];
            end
            default: begin
                ramREN   = 1'b0;
                ramWEN   = 1'b0;
                ramaddr  = '0;
                ramstore = '0;
            end
        endcase
    end

    // Core side: wait follows the request except on the acknowledged port.
    always_comb begin
        iwait = iREN;
        dwait = dreq;
        iload = '0;
        dload = '0;
        if (ack) begin
            if (state == DACC) begin
                dwait[gnt] = 1'b0;
                dload[gnt] = ramload;
            end else begin
                iwait[gnt] = 1'b0;
                iload[gnt] = ramload;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter with CPUS=2: a per-cycle vector table covering
// reset, single fetch, write priority, fairness, error retry, abandon and
// same-core data/fetch ordering, then a hand-written asynchronous mid-access
// reset sequence. Expectations follow MEMARB_FAIRNESS_EN when it is defined.
module tb_memory_arbiter;

    localparam int CPUS = 2;

    localparam logic [1:0] FREE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DACC = 2'd1;
    localparam logic [1:0] S_IACC = 2'd2;

    localparam logic [31:0] IA0 = 32'h0000_0040;
    localparam logic [31:0] IA1 = 32'h0000_0140;
    localparam logic [31:0] DA0 = 32'h0000_0200;
    localparam logic [31:0] DA1 = 32'h0000_0080;
    localparam logic [31:0] DS0 = 32'h0000_5555;
    localparam logic [31:0] DS1 = 32'h0000_1234;

`ifdef MEMARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                  CLK;
    logic                  nRST;
    logic [CPUS-1:0]       iREN, dREN, dWEN;
    logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
    logic [CPUS-1:0]       iwait, dwait;
    logic [CPUS-1:0][31:0] iload, dload;
    logic                  ramREN, ramWEN;
    logic [31:0]           ramaddr, ramstore, ramload;
    logic [1:0]            ramstate;
    logic [1:0]            arb_state;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    memory_arbiter #(.CPUS(CPUS)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .iREN      (iREN),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .iaddr     (iaddr),
        .daddr     (daddr),
        .dstore    (dstore),
        .iwait     (iwait),
        .dwait     (dwait),
        .iload     (iload),
        .dload     (dload),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .arb_state (arb_state)
    );

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        bit          rst;
        logic [1:0]  ir, dr, dw, rs;
        logic [31:0] rl;
        logic [1:0]  e_st, e_iw, e_dw;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic [63:0] e_il, e_dl;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input string nm, input bit rst,
                                input logic [1:0] ir, input logic [1:0] dr,
                                input logic [1:0] dw, input logic [1:0] rs,
                                input logic [31:0] rl, input logic [1:0] st,
                                input logic [1:0] iw, input logic [1:0] dwe,
                                input logic ren, input logic wen,
                                input logic [31:0] addr, input logic [31:0] store,
                                input logic [63:0] il, input logic [63:0] dl);
        vec_t v;
        v.name = nm;  v.rst = rst;
        v.ir = ir;    v.dr = dr;    v.dw = dw;   v.rs = rs;  v.rl = rl;
        v.e_st = st;  v.e_iw = iw;  v.e_dw = dwe;
        v.e_ren = ren; v.e_wen = wen;
        v.e_addr = addr; v.e_store = store;
        v.e_il = il;  v.e_dl = dl;
        return v;
    endfunction

    function automatic logic [63:0] lo(input logic [31:0] x);
        return {32'h0, x};
    endfunction

    function automatic logic [63:0] hi(input logic [31:0] x);
        return {x, 32'h0};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_row(input vec_t v);
        chk({v.name, ".state"},    64'(arb_state), 64'(v.e_st));
        chk({v.name, ".iwait"},    64'(iwait),     64'(v.e_iw));
        chk({v.name, ".dwait"},    64'(dwait),     64'(v.e_dw));
        chk({v.name, ".ramREN"},   64'(ramREN),    64'(v.e_ren));
        chk({v.name, ".ramWEN"},   64'(ramWEN),    64'(v.e_wen));
        chk({v.name, ".ramaddr"},  64'(ramaddr),   64'(v.e_addr));
        chk({v.name, ".ramstore"}, 64'(ramstore),  64'(v.e_store));
        chk({v.name, ".iload"},    64'(iload),     v.e_il);
        chk({v.name, ".dload"},    64'(dload),     v.e_dl);
    endtask

    // ---------------- driver ----------------
    task automatic drive_row(input vec_t v);
        nRST     = v.rst ? 1'b0 : 1'b1;
        iREN     = v.ir;
        dREN     = v.dr;
        dWEN     = v.dw;
        ramstate = v.rs;
        ramload  = v.rl;
    endtask

    initial begin
        nRST     = 1'b0;
        iREN     = '0;
        dREN     = '0;
        dWEN     = '0;
        iaddr    = {IA1, IA0};
        daddr    = {DA1, DA0};
        dstore   = {DS1, DS0};
        ramstate = FREE;
        ramload  = '0;

        // reset state, wait bits equal to requests
        vecs.push_back(mk("reset",    1, 2'b10, 2'b00, 2'b01, FREE, 0,            S_IDLE, 2'b10, 2'b01, 0, 0, 0,   0,   0, 0));
        // single fetch, two BUSY cycles then ACCESS
        vecs.push_back(mk("rd_req",   0, 2'b01, 2'b00, 2'b00, FREE, 0,            S_IDLE, 2'b01, 2'b00, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("rd_busy1", 0, 2'b01, 2'b00, 2'b00, BUSY, 0,            S_IACC, 2'b01, 2'b00, 1, 0, IA0, 0,   0, 0));
        vecs.push_back(mk("rd_busy2", 0, 2'b01, 2'b00, 2'b00, BUSY, 0,            S_IACC, 2'b01, 2'b00, 1, 0, IA0, 0,   0, 0));
        vecs.push_back(mk("rd_ack",   0, 2'b01, 2'b00, 2'b00, ACC,  32'hDEADBEEF, S_IACC, 2'b00, 2'b00, 1, 0, IA0, 0,   lo(32'hDEADBEEF), 0));
        vecs.push_back(mk("rd_idle",  0, 2'b00, 2'b00, 2'b00, FREE, 0,            S_IDLE, 2'b00, 2'b00, 0, 0, 0,   0,   0, 0));
        // core1 write beats core0 fetch; fetch follows one IDLE cycle later
        vecs.push_back(mk("wp_req",   0, 2'b01, 2'b00, 2'b10, FREE, 0,            S_IDLE, 2'b01, 2'b10, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("wp_write", 0, 2'b01, 2'b00, 2'b10, ACC,  32'hCAFE0001, S_DACC, 2'b01, 2'b00, 0, 1, DA1, DS1, 0, hi(32'hCAFE0001)));
        vecs.push_back(mk("wp_gap",   0, 2'b01, 2'b00, 2'b00, FREE, 0,            S_IDLE, 2'b01, 2'b00, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("wp_fetch", 0, 2'b01, 2'b00, 2'b00, ACC,  32'h11112222, S_IACC, 2'b00, 2'b00, 1, 0, IA0, 0,   lo(32'h11112222), 0));
        vecs.push_back(mk("wp_idle",  0, 2'b00, 2'b00, 2'b00, FREE, 0,            S_IDLE, 2'b00, 2'b00, 0, 0, 0,   0,   0, 0));
        // fairness: both cores hold dREN, RAM acknowledges at once
        vecs.push_back(mk("fr_rst",   1, 2'b00, 2'b11, 2'b00, ACC,  0,            S_IDLE, 2'b00, 2'b11, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("fr_idle0", 0, 2'b00, 2'b11, 2'b00, ACC,  32'hA0,       S_IDLE, 2'b00, 2'b11, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("fr_g1",    0, 2'b00, 2'b11, 2'b00, ACC,  32'hA1,       S_DACC, 2'b00, 2'b10, 1, 0, DA0, DS0, 0, lo(32'hA1)));
        vecs.push_back(mk("fr_idle1", 0, 2'b00, 2'b11, 2'b00, ACC,  32'hA2,       S_IDLE, 2'b00, 2'b11, 0, 0, 0,   0,   0, 0));
        vecs.push_back(FAIR ?
                       mk("fr_g2",    0, 2'b00, 2'b11, 2'b00, ACC,  32'hA3,       S_DACC, 2'b00, 2'b01, 1, 0, DA1, DS1, 0, hi(32'hA3)) :
                       mk("fr_g2",    0, 2'b00, 2'b11, 2'b00, ACC,  32'hA3,       S_DACC, 2'b00, 2'b10, 1, 0, DA0, DS0, 0, lo(32'hA3)));
        vecs.push_back(mk("fr_idle2", 0, 2'b00, 2'b11, 2'b00, ACC,  32'hA4,       S_IDLE, 2'b00, 2'b11, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("fr_g3",    0, 2'b00, 2'b11, 2'b00, ACC,  32'hA5,       S_DACC, 2'b00, 2'b10, 1, 0, DA0, DS0, 0, lo(32'hA5)));
        vecs.push_back(mk("fr_idle3", 0, 2'b00, 2'b11, 2'b00, ACC,  32'hA6,       S_IDLE, 2'b00, 2'b11, 0, 0, 0,   0,   0, 0));
        vecs.push_back(FAIR ?
                       mk("fr_g4",    0, 2'b00, 2'b11, 2'b00, ACC,  32'hA7,       S_DACC, 2'b00, 2'b01, 1, 0, DA1, DS1, 0, hi(32'hA7)) :
                       mk("fr_g4",    0, 2'b00, 2'b11, 2'b00, ACC,  32'hA7,       S_DACC, 2'b00, 2'b10, 1, 0, DA0, DS0, 0, lo(32'hA7)));
        vecs.push_back(mk("fr_done",  0, 2'b00, 2'b00, 2'b00, FREE, 0,            S_IDLE, 2'b00, 2'b00, 0, 0, 0,   0,   0, 0));
        // ERROR: no acknowledge, back through IDLE, retried
        vecs.push_back(mk("er_req",   0, 2'b00, 2'b01, 2'b00, FREE, 0,            S_IDLE, 2'b00, 2'b01, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("er_err",   0, 2'b00, 2'b01, 2'b00, ERR,  32'h55,       S_DACC, 2'b00, 2'b01, 1, 0, DA0, DS0, 0, 0));
        vecs.push_back(mk("er_idle",  0, 2'b00, 2'b01, 2'b00, ACC,  32'h66,       S_IDLE, 2'b00, 2'b01, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("er_ack",   0, 2'b00, 2'b01, 2'b00, ACC,  32'h77,       S_DACC, 2'b00, 2'b00, 1, 0, DA0, DS0, 0, lo(32'h77)));
        vecs.push_back(mk("er_done",  0, 2'b00, 2'b00, 2'b00, FREE, 0,            S_IDLE, 2'b00, 2'b00, 0, 0, 0,   0,   0, 0));
        // abandoned fetch: request drops while granted, ACCESS is ignored
        vecs.push_back(mk("ab_req",   0, 2'b10, 2'b00, 2'b00, FREE, 0,            S_IDLE, 2'b10, 2'b00, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("ab_busy",  0, 2'b10, 2'b00, 2'b00, BUSY, 0,            S_IACC, 2'b10, 2'b00, 1, 0, IA1, 0,   0, 0));
        vecs.push_back(mk("ab_drop",  0, 2'b00, 2'b00, 2'b00, ACC,  32'h99,       S_IACC, 2'b00, 2'b00, 1, 0, IA1, 0,   0, 0));
        vecs.push_back(mk("ab_idle",  0, 2'b00, 2'b00, 2'b00, ACC,  32'h98,       S_IDLE, 2'b00, 2'b00, 0, 0, 0,   0,   0, 0));
        // same core: read+write+fetch; write wins, fetch after the IDLE gap
        vecs.push_back(mk("sc_req",   0, 2'b01, 2'b01, 2'b01, FREE, 0,            S_IDLE, 2'b01, 2'b01, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("sc_data",  0, 2'b01, 2'b01, 2'b01, ACC,  32'h5,        S_DACC, 2'b01, 2'b00, 0, 1, DA0, DS0, 0, lo(32'h5)));
        vecs.push_back(mk("sc_gap",   0, 2'b01, 2'b00, 2'b00, FREE, 0,            S_IDLE, 2'b01, 2'b00, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk("sc_fetch", 0, 2'b01, 2'b00, 2'b00, ACC,  32'h6,        S_IACC, 2'b00, 2'b00, 1, 0, IA0, 0,   lo(32'h6), 0));
        vecs.push_back(mk("sc_done",  0, 2'b00, 2'b00, 2'b00, FREE, 0,            S_IDLE, 2'b00, 2'b00, 0, 0, 0,   0,   0, 0));

        repeat (2) @(negedge CLK);

        // one row per cycle: drive on the falling edge, check before the rise
        for (int i = 0; i < vecs.size(); i++) begin
            drive_row(vecs[i]);
            #1;
            check_row(vecs[i]);
            @(negedge CLK);
        end

        // asynchronous reset in the middle of a BUSY fetch
        nRST     = 1'b1;
        iREN     = 2'b01;
        ramstate = BUSY;
        ramload  = '0;
        @(negedge CLK);
        #1;
        chk("abort.pre_state",  64'(arb_state), 64'(S_IACC));
        chk("abort.pre_ren",    64'(ramREN),    64'(1'b1));
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        chk("abort.state",      64'(arb_state), 64'(S_IDLE));
        chk("abort.ren",        64'(ramREN),    64'(1'b0));
        chk("abort.addr",       64'(ramaddr),   64'(0));
        chk("abort.iwait",      64'(iwait),     64'(2'b01));
        ramstate = ACC;
        ramload  = 32'h0000_0BAD;
        #1;
        chk("abort.iload",      64'(iload),     64'(0));
        chk("abort.noack",      64'(iwait),     64'(2'b01));
        @(negedge CLK);
        nRST     = 1'b1;
        ramstate = BUSY;
        #1;
        chk("abort.rel_state",  64'(arb_state), 64'(S_IDLE));
        @(negedge CLK);
        #1;
        chk("abort.regnt_state", 64'(arb_state), 64'(S_IACC));
        chk("abort.regnt_addr",  64'(ramaddr),   64'(IA0));
        ramstate = ACC;
        ramload  = 32'h0000_1357;
        #1;
        chk("abort.ack_iwait",  64'(iwait),     64'(2'b00));
        chk("abort.ack_iload",  64'(iload),     lo(32'h0000_1357));
        @(negedge CLK);
        iREN     = 2'b00;
        ramstate = FREE;
        #1;
        chk("abort.done_state", 64'(arb_state), 64'(S_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
